// File: rtl/muldiv_pkg.sv
// muldiv_pkg
//   Shared definitions for the iterative multiply/divide unit:
//   FSM state encoding, op codes and the default operand width.
//   The divider datapath is compiled in only when MULDIV_DIV_EN is defined.
package muldiv_pkg;

    localparam int DEFAULT_WIDTH = 16;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } muldiv_state_t;

endpackage : muldiv_pkg

// File: rtl/muldiv_div_step.sv
// muldiv_div_step
//   One combinational restoring-division step. The next dividend bit is
//   shifted into the partial remainder; if the divisor fits, it is
//   subtracted and the quotient bit is 1, otherwise the shifted value is
//   kept and the quotient bit is 0.
//   Ports:
//     rem_in       : partial remainder from the previous step (always < divisor)
//     dividend_bit : next dividend bit, MSB first
//     divisor      : divisor
//     rem_out      : updated partial remainder
//     quot_bit     : quotient bit produced by this step
module muldiv_div_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dividend_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             quot_bit
);

    logic [WIDTH:0] shifted;

    // The shifted remainder needs one extra bit; once the divisor has been
    // subtracted (or not) the result is again below the divisor and fits in
    // WIDTH bits. A zero divisor always subtracts, so the remainder simply
    // accumulates the dividend and the quotient comes out all ones.
    always_comb begin
        shifted  = {rem_in, dividend_bit};
        quot_bit = (shifted >= {1'b0, divisor});
        rem_out  = quot_bit ? WIDTH'(shifted - {1'b0, divisor})
                            : WIDTH'(shifted);
    end

endmodule : muldiv_div_step

// File: rtl/muldiv_unit.sv
// muldiv_unit
//   Iterative unsigned WIDTH x WIDTH multiply / WIDTH / WIDTH divide.
//   A request is latched on start while idle, runs WIDTH single-bit
//   iterations and presents the result with a one-cycle done pulse.
//   Results and div_by_zero hold until the next accepted request.
//   Build option:
//     MULDIV_DIV_EN defined   : restoring divider and div_by_zero built in.
//     MULDIV_DIV_EN undefined : multiplier only; a divide request runs the
//                               same sequence and returns zeros.
//   Ports:
//     clk, rst              : clock, synchronous active-high reset
//     start, op             : request strobe and op (0 = mul, 1 = div)
//     operand_a, operand_b  : multiplicand/dividend, multiplier/divisor
//     busy, done            : request in flight, one-cycle result strobe
//     result_lo, result_hi  : product low/high, or quotient/remainder
//     div_by_zero           : divide with a zero divisor
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_by_zero
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    muldiv_state_t      state;
    logic [CNT_W-1:0]   count;
    logic               op_q;
    logic               last_iter;

    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_next;

`ifdef MULDIV_DIV_EN
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   rem_next;
    logic [WIDTH-1:0]   quot_q;
    logic [WIDTH-1:0]   divisor_q;
    logic               quot_bit;

    // quot_q starts out holding the dividend; each step consumes its MSB and
    // shifts the new quotient bit in at the bottom.
    muldiv_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_in       (rem_q),
        .dividend_bit (quot_q[WIDTH-1]),
        .divisor      (divisor_q),
        .rem_out      (rem_next),
        .quot_bit     (quot_bit)
    );
`endif

    assign busy      = (state != IDLE);
    assign last_iter = (count == CNT_W'(WIDTH - 1));

    // Shift-add: the multiplier is consumed LSB first while the multiplicand
    // moves left, so each step adds the correctly weighted partial product.
    always_comb begin
        acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
    end

    // Control FSM and datapath registers. The final iteration's next-state
    // values are written straight into the result registers so they are
    // valid in the same cycle that done is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            count       <= '0;
            op_q        <= OP_MUL;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            done        <= 1'b0;
            result_lo   <= '0;
            result_hi   <= '0;
            div_by_zero <= 1'b0;
`ifdef MULDIV_DIV_EN
            rem_q       <= '0;
            quot_q      <= '0;
            divisor_q   <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= RUN;
                        count       <= '0;
                        op_q        <= op;
                        mcand_q     <= {{WIDTH{1'b0}}, operand_a};
                        mplier_q    <= operand_b;
                        acc_q       <= '0;
                        result_lo   <= '0;
                        result_hi   <= '0;
                        div_by_zero <= 1'b0;
`ifdef MULDIV_DIV_EN
                        rem_q       <= '0;
                        quot_q      <= operand_a;
                        divisor_q   <= operand_b;
`endif
                    end
                end
                RUN: begin
                    count    <= count + 1'b1;
                    acc_q    <= acc_next;
                    mcand_q  <= {mcand_q[2*WIDTH-2:0], 1'b0};
                    mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
                    rem_q    <= rem_next;
                    quot_q   <= {quot_q[WIDTH-2:0], quot_bit};
`endif
                    if (last_iter) begin
                        state <= DONE;
                        done  <= 1'b1;
                        if (op_q == OP_MUL) begin
                            {result_hi, result_lo} <= acc_next;
                        end else begin
`ifdef MULDIV_DIV_EN
                            result_lo   <= {quot_q[WIDTH-2:0], quot_bit};
                            result_hi   <= rem_next;
                            div_by_zero <= (divisor_q == '0);
`else
                            result_lo   <= '0;
                            result_hi   <= '0;
`endif
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule : muldiv_unit

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit
//   Scoreboard bench for muldiv_unit (WIDTH = 16). Requests are driven a
//   few ns after a rising edge; every accepted request pushes its expected
//   result, computed with plain arithmetic, into a queue. A monitor on the
//   falling edge compares busy, done and the result outputs every cycle
//   against the bench's own timeline of when requests were accepted.
//   Honours MULDIV_DIV_EN the same way the design does.
module tb_muldiv_unit;

    typedef struct packed {
        logic [15:0] lo;
        logic [15:0] hi;
        logic        dbz;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [15:0] operand_a = '0;
    logic [15:0] operand_b = '0;
    logic        busy;
    logic        done;
    logic [15:0] result_lo;
    logic [15:0] result_hi;
    logic        div_by_zero;

    int   cyc = 0;
    int   last_k = -100;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t cur_exp = '0;

    muldiv_unit #(.WIDTH(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .busy        (busy),
        .done        (done),
        .result_lo   (result_lo),
        .result_hi   (result_hi),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // Cycle numbering: cyc is the index of the cycle that follows each
    // rising edge, so a request driven during cycle k is accepted at the
    // edge closing it.
    always @(posedge clk) cyc <= cyc + 1;

    // Reference behaviour from the arithmetic definition.
    function automatic exp_t refModel(input logic o, input logic [15:0] a,
                                      input logic [15:0] b);
        exp_t        e;
        logic [31:0] p;
        e = '0;
        if (o == 1'b0) begin
            p = 32'(a) * 32'(b);
            e.hi = p[31:16];
            e.lo = p[15:0];
        end else begin
`ifdef MULDIV_DIV_EN
            if (b == 16'd0) begin
                e.lo  = 16'hFFFF;
                e.hi  = a;
                e.dbz = 1'b1;
            end else begin
                e.lo = a / b;
                e.hi = a % b;
            end
`endif
        end
        return e;
    endfunction

    // Drives one start pulse in the current cycle and returns one cycle
    // later. The bench knows the unit is free 18 cycles after an accept.
    task automatic applyStimulus(input logic o, input logic [15:0] a,
                                 input logic [15:0] b);
        op        = o;
        operand_a = a;
        operand_b = b;
        start     = 1'b1;
        if (cyc >= last_k + 18) begin
            last_k = cyc;
            sb.push_back(refModel(o, a, b));
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Synchronous reset across one edge; any in-flight request is dropped.
    task automatic resetDut();
        rst    = 1'b1;
        last_k = -100;
        sb.delete();
        cur_exp = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic exp_busy,
                               input logic exp_done, input exp_t exp_res);
        @(negedge clk);
        checks++;
        if (busy !== exp_busy || done !== exp_done || result_lo !== exp_res.lo ||
            result_hi !== exp_res.hi || div_by_zero !== exp_res.dbz) begin
            errors++;
            $display("[TB] FAIL %s: got busy=%b done=%b lo=%h hi=%h dbz=%b, exp busy=%b done=%b lo=%h hi=%h dbz=%b",
                     name, busy, done, result_lo, result_hi, div_by_zero,
                     exp_busy, exp_done, exp_res.lo, exp_res.hi, exp_res.dbz);
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: busy must cover k+1..k+17, done only at k+17, and results
    // are zero while running, the popped expectation from done onwards.
    always @(negedge clk) begin
        logic busy_exp;
        logic done_exp;
        if (!rst) begin
            busy_exp = (cyc >= last_k + 1) && (cyc <= last_k + 17);
            done_exp = (cyc == last_k + 17);
            checks++;
            if (busy !== busy_exp) begin
                errors++;
                $display("[TB] FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, busy_exp);
            end
            checks++;
            if (done !== done_exp) begin
                errors++;
                $display("[TB] FAIL done cyc=%0d got=%b exp=%b", cyc, done, done_exp);
            end
            if (done_exp) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL scoreboard empty at done cyc=%0d", cyc);
                end else begin
                    cur_exp = sb.pop_front();
                end
            end else if (busy_exp) begin
                cur_exp = '0;
            end
            checks++;
            if (result_lo !== cur_exp.lo || result_hi !== cur_exp.hi ||
                div_by_zero !== cur_exp.dbz) begin
                errors++;
                $display("[TB] FAIL result cyc=%0d got lo=%h hi=%h dbz=%b exp lo=%h hi=%h dbz=%b",
                         cyc, result_lo, result_hi, div_by_zero,
                         cur_exp.lo, cur_exp.hi, cur_exp.dbz);
            end
        end
    end

    initial begin
        logic        r_op;
        logic [15:0] r_a;
        logic [15:0] r_b;

        idleCycles(3);
        rst = 1'b0;
        checkOutput("reset_state", 1'b0, 1'b0, '0);

        // Directed cases, each followed by enough idle time to drain.
        applyStimulus(1'b0, 16'd300, 16'd250);
        idleCycles(18);
        applyStimulus(1'b0, 16'hFFFF, 16'hFFFF);
        idleCycles(18);
        applyStimulus(1'b1, 16'd1000, 16'd7);
        idleCycles(18);
        applyStimulus(1'b1, 16'h1234, 16'h0000);
        idleCycles(18);

        // A second start while busy is ignored and operand changes have no
        // effect; the next request at k+18 is accepted.
        applyStimulus(1'b0, 16'd3, 16'd5);
        idleCycles(3);
        applyStimulus(1'b0, 16'd9, 16'd9);
        operand_a = 16'hABCD;
        operand_b = 16'h4321;
        op        = 1'b1;
        idleCycles(13);
        applyStimulus(1'b0, 16'd6, 16'd6);
        idleCycles(18);

        // Abort a divide at k+8; outputs must be back at reset values.
        applyStimulus(1'b1, 16'd5000, 16'd3);
        idleCycles(7);
        resetDut();
        checkOutput("after_abort", 1'b0, 1'b0, '0);
        applyStimulus(1'b0, 16'd6, 16'd7);
        idleCycles(18);

        // Random traffic with random gaps, including starts while busy.
        for (int i = 0; i < 40; i++) begin
            r_op = 1'($urandom_range(0, 1));
            r_a  = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       r_b = 16'd0;
                1:       r_b = 16'($urandom_range(1, 15));
                default: r_b = 16'($urandom);
            endcase
            applyStimulus(r_op, r_a, r_b);
            idleCycles($urandom_range(0, 20));
        end
        idleCycles(20);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain got=%0d pending exp=0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_muldiv_unit
